// File: rtl/seq_nibble_adder_ctrl_if.sv
// Handshake bundle for seq_nibble_adder_ctrl.
//   master : operand producer / result consumer side (drives in_valid, a, b, cin, sub,
//            out_ready; observes in_ready, out_valid, sum, cout, ovf)
//   slave  : the adder controller itself
interface seq_nibble_adder_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/seq_nibble_adder_ctrl.sv
// Multi-cycle WIDTH-bit adder: one 4-bit carry-increment slice walks the operands
// LSB nibble first, one nibble per clock (WIDTH/4 cycles per result).
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - seq_nibble_adder_ctrl_if.slave: in_valid/in_ready + a, b, cin, sub on the
//            operand side; out_valid/out_ready + sum, cout, ovf on the result side
//
// Optional feature: define SEQ_ADDER_SUBTRACT_EN to honour sub (A - B, cin ignored).
// Without it sub is ignored and the result is always A + B + cin.
module seq_nibble_adder_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_nibble_adder_ctrl_if.slave bus
);

  localparam int unsigned N  = WIDTH / 4;
  localparam int unsigned KW = $clog2(N);
  localparam logic [KW-1:0] KLast = KW'(N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [KW-1:0]    k_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;
`ifdef SEQ_ADDER_SUBTRACT_EN
  logic             sub_q;
`endif

  // Carry-in actually used for nibble 0.
  logic cin_eff;
`ifdef SEQ_ADDER_SUBTRACT_EN
  assign cin_eff = bus.sub ? 1'b1 : bus.cin;
`else
  assign cin_eff = bus.cin;
`endif

  // Nibble slice: raw 4-bit add, then increment by the running carry.
  logic [3:0] a_nib;
  logic [3:0] b_nib;
  logic [4:0] raw;
  logic [4:0] inc;
  logic [3:0] s_nib;
  logic       c_nib;
  logic       ovf_nib;

  always_comb begin
    a_nib = a_q[{k_q, 2'b00} +: 4];
`ifdef SEQ_ADDER_SUBTRACT_EN
    b_nib = b_q[{k_q, 2'b00} +: 4] ^ {4{sub_q}};
`else
    b_nib = b_q[{k_q, 2'b00} +: 4];
`endif
    raw   = {1'b0, a_nib} + {1'b0, b_nib};
    inc   = {1'b0, raw[3:0]} + {4'b0000, carry_q};
    s_nib = inc[3:0];
    // Both carries can never be set together, so OR is exact.
    c_nib = raw[4] | inc[4];
    // a^b^s at bit 3 recovers the carry into the nibble MSB.
    ovf_nib = a_nib[3] ^ b_nib[3] ^ s_nib[3] ^ c_nib;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      k_q         <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SEQ_ADDER_SUBTRACT_EN
      sub_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            carry_q    <= cin_eff;
`ifdef SEQ_ADDER_SUBTRACT_EN
            sub_q      <= bus.sub;
`endif
            sum_q      <= '0;
            k_q        <= '0;
            in_ready_q <= 1'b0;
            state_q    <= StRun;
          end
        end
        StRun: begin
          sum_q[{k_q, 2'b00} +: 4] <= s_nib;
          carry_q                  <= c_nib;
          if (k_q == KLast) begin
            k_q         <= '0;
            cout_q      <= c_nib;
            ovf_q       <= ovf_nib;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_seq_nibble_adder_ctrl.sv
module tb_seq_nibble_adder_ctrl;

  localparam int unsigned W = 32;
  localparam int Lat = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_nibble_adder_ctrl_if #(.WIDTH(W)) bus ();

  seq_nibble_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_in_ready(input string tag);
    int i;
    for (i = 0; i < 40 && bus.in_ready !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    chk({tag, " in_ready before accept"}, 32'(bus.in_ready), 32'd1);
  endtask

  // Wait for out_valid after an accept; returns cycles counted.
  task automatic wait_result(output int lat);
    bit seen;
    seen = 0;
    lat  = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.out_valid === 1'b1) seen = 1;
    end
  endtask

  // Called at posedge+1. Full transaction with immediate drain.
  task automatic run_txn(input vec_t v, input string tag);
    int lat;
    wait_in_ready(tag);
    bus.in_valid = 1'b1;
    bus.a = v.a; bus.b = v.b; bus.cin = v.cin; bus.sub = v.sub;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_result(lat);
    chk({tag, " latency"}, 32'(lat), 32'(Lat));
    chk({tag, " sum"},  bus.sum, v.sum);
    chk({tag, " cout"}, 32'(bus.cout), 32'(v.cout));
    chk({tag, " ovf"},  32'(bus.ovf),  32'(v.ovf));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int          lat;
    int          gap;
    logic [31:0] r1_sum;
    logic        r1_cout;
    logic        r1_ovf;
    bit          got1;

    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[2] = '{32'h1234_5678, 32'h0FED_CBA8, 1'b1, 1'b0, 32'h2222_2221, 1'b0, 1'b0};
    vecs[3] = '{32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 32'h0000_0007, 1'b0, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[5] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
`ifdef SEQ_ADDER_SUBTRACT_EN
    vecs[6] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[7] = '{32'h0000_000A, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0007, 1'b1, 1'b0};
`else
    vecs[6] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'h0000_000C, 1'b0, 1'b0};
    vecs[7] = '{32'h0000_000A, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_000D, 1'b0, 1'b0};
`endif

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst sum",       bus.sum,            32'd0);
    chk("rst cout",      32'(bus.cout),      32'd0);
    chk("rst ovf",       32'(bus.ovf),       32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Backpressure, with in_valid pulses during RUN and DONE carrying other operands.
    wait_in_ready("bp");
    bus.in_valid = 1'b1;
    bus.a = 32'h1234_5678; bus.b = 32'h0FED_CBA8; bus.cin = 1'b1; bus.sub = 1'b0;
    @(posedge clk); #1;
    bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF; bus.cin = 1'b0;
    wait_result(lat);
    chk("bp latency", 32'(lat), 32'(Lat));
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp sum c%0d", i),       bus.sum,            32'h2222_2221);
      chk($sformatf("bp cout c%0d", i),      32'(bus.cout),      32'd0);
      chk($sformatf("bp ovf c%0d", i),       32'(bus.ovf),       32'd0);
      chk($sformatf("bp in_ready c%0d", i),  32'(bus.in_ready),  32'd0);
      chk($sformatf("bp out_valid c%0d", i), 32'(bus.out_valid), 32'd1);
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("bp drain in_ready",  32'(bus.in_ready),  32'd1);
    chk("bp drain out_valid", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset after the 3rd RUN edge.
    bus.in_valid = 1'b1;
    bus.a = 32'h1111_1111; bus.b = 32'h2222_2222; bus.cin = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid-run partial sum", bus.sum, 32'h0000_0333);
    rst_n = 1'b0;
    #1;
    chk("async rst sum",       bus.sum,            32'd0);
    chk("async rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("async rst in_ready",  32'(bus.in_ready),  32'd1);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_txn(vecs[3], "post-rst 3+4");

    // Back-to-back with out_ready tied high.
    wait_in_ready("b2b");
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a = 32'hFFFF_FFFF; bus.b = 32'h0000_0001; bus.cin = 1'b0; bus.sub = 1'b0;
    @(posedge clk); #1;
    bus.a = 32'h7FFF_FFFF; bus.b = 32'h0000_0001;
    got1 = 0; gap = 0;
    r1_sum = 'x; r1_cout = 1'bx; r1_ovf = 1'bx;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      gap++;
      if (bus.out_valid === 1'b1 && !got1) begin
        got1 = 1;
        r1_sum = bus.sum; r1_cout = bus.cout; r1_ovf = bus.ovf;
      end
      if (got1 && bus.in_ready === 1'b1) break;
    end
    @(posedge clk); #1;
    gap++;
    bus.in_valid = 1'b0;
    chk("b2b issue interval", 32'(gap), 32'(Lat + 2));
    chk("b2b r1 sum",  r1_sum,        32'h0000_0000);
    chk("b2b r1 cout", 32'(r1_cout),  32'd1);
    chk("b2b r1 ovf",  32'(r1_ovf),   32'd0);
    wait_result(lat);
    chk("b2b r2 latency", 32'(lat), 32'(Lat));
    chk("b2b r2 sum",  bus.sum,       32'h8000_0000);
    chk("b2b r2 cout", 32'(bus.cout), 32'd0);
    chk("b2b r2 ovf",  32'(bus.ovf),  32'd1);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("b2b end in_ready", 32'(bus.in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_nibble_adder_ctrl.md
# seq_nibble_adder_ctrl

Multi-cycle controller that performs a WIDTH-bit addition by sequencing one internal 4-bit carry-increment slice over the operands, least-significant nibble first, one nibble per clock. It sits between an operand producer and a result consumer, with a valid/ready handshake on each side. It trades latency (WIDTH/4 cycles) for area: one 4-bit slice plus carry register replaces a full-width adder.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of 4, minimum 8
- clk  input  1  rising-edge clock, single clock domain
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b, cin, sub valid
- in_ready  output  1  controller can accept operands; high only in IDLE
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in to nibble 0
- sub  input  1  subtract request; see Configuration
- out_valid  output  1  result fields valid; high only in DONE
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of bit WIDTH-1
- ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB)

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- IDLE: in_ready=1. On in_valid at a clk edge: capture a, b, effective carry-in and opcode into registers; clear sum register; slice index k=0; go to RUN.
- RUN: each edge computes nibble k: {c, s} = A[4k+3:4k] + B'[4k+3:4k] + carry_reg; writes s into sum[4k+3:4k]; carry_reg<=c; k<=k+1. B' = B, or ~B under subtract. After nibble N-1 (N=WIDTH/4), latch cout and ovf, go to DONE.
- The slice computes the raw 4-bit nibble sum first, then increments it by carry_reg (carry-increment structure). Carry-out of the slice = nibble carry OR increment carry.
- DONE: out_valid=1, sum/cout/ovf stable. On out_ready at an edge: go to IDLE. Outputs keep their values until the next accept.
- in_valid outside IDLE ignored; operands not re-sampled during RUN.
- out_ready outside DONE ignored.
- Arithmetic: modulo 2^WIDTH; cout is the unsigned carry; ovf is computed from the carry into and out of bit WIDTH-1.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, k=0, carry_reg=0. Takes effect immediately, including mid-RUN or in DONE; the pending result is discarded.
- Accept at edge E0. RUN occupies edges E1..EN. out_valid rises after EN, i.e. N cycles after accept (8 for WIDTH=32).
- Minimum issue interval: N+2 cycles. Breakdown: accept, N RUN cycles, DONE with immediate out_ready, then back to IDLE.
- Backpressure: DONE holds indefinitely while out_ready=0. in_ready stays 0 during this time.
- in_ready and out_valid are registered state decodes, not combinational from inputs.

## Configuration
- Macro: SEQ_ADDER_SUBTRACT_EN.
- Defined: when sub=1 at accept, B is inverted per nibble and the effective carry-in is 1, giving A-B. cin is ignored when sub=1. cout=1 means no borrow.
- Undefined: the sub port exists but is ignored, and the operation is always A+B+cin. No inversion logic is synthesized.

## Test plan
- WIDTH=32, a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1, ovf=0, with out_valid rising exactly 8 cycles after accept.
- a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1. Also a=0x12345678, b=0x0FEDCBA8, cin=1 -> sum=0x22222221, cout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> sum/cout/ovf stable and in_ready=0 throughout. A new in_valid pulse during RUN and DONE does not change the result.
- Reset: assert rst_n=0 after the 3rd RUN edge -> outputs immediately sum=0, out_valid=0, in_ready=1. After release, a fresh 3+4 completes correctly with sum=7.
- With SEQ_ADDER_SUBTRACT_EN: a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0. Without the macro, same stimulus -> sum=0x0000000C.
- Back-to-back: two transactions with out_ready tied high -> second accept occurs N+2 cycles after the first, and both results are correct.
